fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream.sv | 118 +++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - show-ahead FIFO read port to valid/ready stream with frame tagging
// Two-entry skid buffer; entry 0 is the stream head and drives out_data/out_last directly.
module fifo_rd_stream #(
    parameter int DATA_SIZE = 16,
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 rempty,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic                 rinc,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [CNT_W-1:0]     underrun_cnt
);

    localparam int POS_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

    logic [1:0]           count, count_n;
    logic [POS_W-1:0]     pos, pos_n;
    logic [DATA_SIZE-1:0] data0_n, data1, data1_n;
    logic                 last0_n, last1, last1_n;
    logic                 valid_n;
    logic                 push, pop, frame_end;

    // No out_ready term here: the read strobe only depends on local occupancy.
    assign rinc      = !rrst && en && !flush && !rempty && (count != 2'd2);
    assign push      = rinc;
    assign pop       = out_valid && out_ready && !flush;
    assign frame_end = (pos == POS_W'(FRAME_LEN - 1));

    always_comb begin
        count_n = count;
        pos_n   = pos;
        data0_n = out_data;
        last0_n = out_last;
        data1_n = data1;
        last1_n = last1;
        if (flush) begin
            count_n = 2'd0;
            pos_n   = '0;
            last0_n = 1'b0;
        end else begin
            if (push) begin
                pos_n = frame_end ? '0 : pos + POS_W'(1);
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        data0_n = rdata;
                        last0_n = frame_end;
                    end else begin
                        data1_n = rdata;
                        last1_n = frame_end;
                    end
                    count_n = count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        data0_n = data1;
                        last0_n = last1;
                    end else begin
                        last0_n = 1'b0;
                    end
                    count_n = count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        data0_n = rdata;
                        last0_n = frame_end;
                    end else begin
                        data0_n = data1;
                        last0_n = last1;
                        data1_n = rdata;
                        last1_n = frame_end;
                    end
                end
                default: ;
            endcase
        end
        valid_n = (count_n != 2'd0);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            count     <= 2'd0;
            pos       <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            data1     <= '0;
            last1     <= 1'b0;
        end else begin
            count     <= count_n;
            pos       <= pos_n;
            out_data  <= data0_n;
            out_last  <= last0_n;
            out_valid <= valid_n;
            data1     <= data1_n;
            last1     <= last1_n;
        end
    end

    // Starvation is only counted while the consumer is asking and draining is enabled.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            underrun_cnt <= '0;
        end else if (en && out_ready && !out_valid && (underrun_cnt != {CNT_W{1'b1}})) begin
            underrun_cnt <= underrun_cnt + CNT_W'(1);
        end
    end

endmodule
